// File: rtl/pspin_cfg_pkg.sv
// pspin_cfg_pkg: shared PsPIN command types, sizing constants and command ID flattening.
package pspin_cfg_pkg;

    localparam int NUM_CLUSTERS       = 4;
    localparam int NUM_CORES          = 8;
    localparam int NUM_HPU_CMDS       = 4;
    localparam int NUM_CMD_INTERFACES = 3;

    typedef logic [$clog2(NUM_CLUSTERS*NUM_CORES*NUM_HPU_CMDS)-1:0] pspin_cmd_flat_id_t;

    typedef struct packed {
        logic [$clog2(NUM_CLUSTERS)-1:0] cluster_id;
        logic [$clog2(NUM_CORES)-1:0]    core_id;
        logic [$clog2(NUM_HPU_CMDS)-1:0] local_cmd_id;
    } pspin_cmd_id_t;

    typedef struct packed {
        pspin_cmd_id_t cmd_id;
        logic          generate_event;
        logic [1:0]    intf_id;
        logic [31:0]   descr;
    } pspin_cmd_req_t;

    typedef struct packed {
        pspin_cmd_id_t cmd_id;
        logic [31:0]   status;
    } pspin_cmd_resp_t;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

    function automatic pspin_cmd_flat_id_t cmd_id_flatten(input pspin_cmd_id_t id);
        return {id.cluster_id, id.core_id, id.local_cmd_id};
    endfunction

endpackage

// File: rtl/pspin_cmd_rr_arb.sv
// pspin_cmd_rr_arb: round-robin arbiter with one-hot grant; the pointer moves past the winner
// only when the consumer takes the grant (adv_i).
module pspin_cmd_rr_arb #(
    parameter int  N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[IW'((int'(ptr_q) + i) % N)]) begin
                found = 1'b1;
                idx_o = IW'((int'(ptr_q) + i) % N);
            end
        end
        gnt_o = found ? N'(1) << idx_o : '0;
        ptr_d = (adv_i && found) ? ((int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/pspin_cmd_dispatch.sv
// pspin_cmd_dispatch: single-slot command router with an in-flight ID scoreboard and a
// round-robin completion path that forwards only event-generating commands.
module pspin_cmd_dispatch
    import pspin_cfg_pkg::*;
#(
    parameter int  NUM_INTF = NUM_CMD_INTERFACES,
    parameter int  NUM_IDS  = NUM_CLUSTERS*NUM_CORES*NUM_HPU_CMDS,
    localparam int CW       = $clog2(NUM_IDS) + 1,
    localparam int IW       = (NUM_INTF > 1) ? $clog2(NUM_INTF) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cmd_req_valid_i,
    output logic                             cmd_req_ready_o,
    input  pspin_cmd_req_t                   cmd_req_i,
    output logic [NUM_INTF-1:0]              intf_req_valid_o,
    input  logic [NUM_INTF-1:0]              intf_req_ready_i,
    output pspin_cmd_req_t                   intf_req_o,
    input  logic [NUM_INTF-1:0]              intf_resp_valid_i,
    output logic [NUM_INTF-1:0]              intf_resp_ready_o,
    input  pspin_cmd_resp_t [NUM_INTF-1:0]   intf_resp_i,
    output logic                             cmd_resp_valid_o,
    input  logic                             cmd_resp_ready_i,
    output pspin_cmd_resp_t                  cmd_resp_o,
    output logic [CW-1:0]                    inflight_cnt_o,
    output logic                             err_o
);

    slot_state_t        slot_q, slot_d, rsp_q, rsp_d;
    pspin_cmd_req_t     req_q, req_d;
    pspin_cmd_resp_t    resp_q, resp_d, rsp;
    logic [NUM_IDS-1:0] sb_q, sb_d, ev_q, ev_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               req_hs, accept, issue, resp_en, granted, retire, load;
    pspin_cmd_flat_id_t req_fid, rsp_fid;
    logic [NUM_INTF-1:0] gnt;
    logic [IW-1:0]      win;

    pspin_cmd_rr_arb #(.N(NUM_INTF)) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (intf_resp_valid_i),
        .adv_i (resp_en),
        .gnt_o (gnt),
        .idx_o (win)
    );

    always_comb begin
        intf_req_valid_o = (slot_q == SLOT_FULL) ? NUM_INTF'(1) << req_q.intf_id : '0;
        req_hs           = |(intf_req_valid_o & intf_req_ready_i);
        cmd_req_ready_o  = (slot_q == SLOT_EMPTY) || req_hs;
        accept           = cmd_req_valid_i && cmd_req_ready_o;
        req_fid          = cmd_id_flatten(cmd_req_i.cmd_id);
        // duplicate check reads the registered scoreboard, so a same-cycle retire of this ID does not clear it in time
        issue            = accept && (int'(cmd_req_i.intf_id) < NUM_INTF) && !sb_q[req_fid];
        slot_d           = issue ? SLOT_FULL : (req_hs ? SLOT_EMPTY : slot_q);
        req_d            = issue ? cmd_req_i : req_q;
        resp_en           = (rsp_q == SLOT_EMPTY) || cmd_resp_ready_i;
        intf_resp_ready_o = resp_en ? gnt : '0;
        granted           = resp_en && |gnt;
        rsp               = intf_resp_i[win];
        rsp_fid           = cmd_id_flatten(rsp.cmd_id);
        retire            = granted && sb_q[rsp_fid];
        load              = retire && ev_q[rsp_fid];
        rsp_d             = load ? SLOT_FULL : (cmd_resp_ready_i ? SLOT_EMPTY : rsp_q);
        resp_d            = load ? rsp : resp_q;
        sb_d = sb_q;
        ev_d = ev_q;
        if (retire) sb_d[rsp_fid] = 1'b0;
        if (issue) begin
            sb_d[req_fid] = 1'b1;
            ev_d[req_fid] = cmd_req_i.generate_event;
        end
        cnt_d = cnt_q + CW'(issue) - CW'(retire);
        err_d = (accept && !issue) || (granted && !retire);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= SLOT_EMPTY;
            rsp_q  <= SLOT_EMPTY;
            req_q  <= '0;
            resp_q <= '0;
            sb_q   <= '0;
            ev_q   <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            rsp_q  <= rsp_d;
            req_q  <= req_d;
            resp_q <= resp_d;
            sb_q   <= sb_d;
            ev_q   <= ev_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign intf_req_o       = req_q;
    assign cmd_resp_valid_o = (rsp_q == SLOT_FULL);
    assign cmd_resp_o       = resp_q;
    assign inflight_cnt_o   = cnt_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_pspin_cmd_dispatch.sv
// tb_pspin_cmd_dispatch: scenario tasks with randomized payloads checked against an ID-set model.
module tb_pspin_cmd_dispatch;
    import pspin_cfg_pkg::*;

    localparam int NI = NUM_CMD_INTERFACES;
    localparam int ND = NUM_CLUSTERS*NUM_CORES*NUM_HPU_CMDS;

    logic                      clk = 1'b0;
    logic                      rst_i = 1'b0;
    logic                      cmd_req_valid_i, cmd_req_ready_o;
    pspin_cmd_req_t            cmd_req_i, intf_req_o;
    logic [NI-1:0]             intf_req_valid_o, intf_req_ready_i;
    logic [NI-1:0]             intf_resp_valid_i, intf_resp_ready_o;
    pspin_cmd_resp_t [NI-1:0]  intf_resp_i;
    logic                      cmd_resp_valid_o, cmd_resp_ready_i;
    pspin_cmd_resp_t           cmd_resp_o;
    logic [7:0]                inflight_cnt_o;
    logic                      err_o;

    bit mdl_sb[ND];
    bit mdl_ev[ND];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pspin_cmd_dispatch dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .cmd_req_valid_i   (cmd_req_valid_i),
        .cmd_req_ready_o   (cmd_req_ready_o),
        .cmd_req_i         (cmd_req_i),
        .intf_req_valid_o  (intf_req_valid_o),
        .intf_req_ready_i  (intf_req_ready_i),
        .intf_req_o        (intf_req_o),
        .intf_resp_valid_i (intf_resp_valid_i),
        .intf_resp_ready_o (intf_resp_ready_o),
        .intf_resp_i       (intf_resp_i),
        .cmd_resp_valid_o  (cmd_resp_valid_o),
        .cmd_resp_ready_i  (cmd_resp_ready_i),
        .cmd_resp_o        (cmd_resp_o),
        .inflight_cnt_o    (inflight_cnt_o),
        .err_o             (err_o)
    );

    function automatic int mdl_cnt();
        int s = 0;
        foreach (mdl_sb[i]) s += int'(mdl_sb[i]);
        return s;
    endfunction

    function automatic void mdl_clear();
        foreach (mdl_sb[i]) begin
            mdl_sb[i] = 1'b0;
            mdl_ev[i] = 1'b0;
        end
    endfunction

    function automatic pspin_cmd_req_t mk_req(int fid, int intf, bit ev);
        pspin_cmd_req_t r;
        r.cmd_id         = pspin_cmd_id_t'(7'(fid));
        r.generate_event = ev;
        r.intf_id        = 2'(intf);
        r.descr          = $urandom;
        return r;
    endfunction

    function automatic pspin_cmd_resp_t mk_resp(int fid);
        pspin_cmd_resp_t r;
        r.cmd_id = pspin_cmd_id_t'(7'(fid));
        r.status = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cmd_req_valid_i   = 1'b0;
        intf_req_ready_i  = '0;
        intf_resp_valid_i = '0;
        cmd_resp_ready_i  = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        cmd_req_i   = '0;
        intf_resp_i = '0;
        rst_i = 1'b1;
        tick();
        tick();
        n_chk++;
        if ({cmd_req_ready_o, intf_req_valid_o, intf_resp_ready_o, cmd_resp_valid_o, inflight_cnt_o, err_o} !== 17'h10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h want 10000", {cmd_req_ready_o, intf_req_valid_o, intf_resp_ready_o, cmd_resp_valid_o, inflight_cnt_o, err_o});
        end
        n_chk++;
        if ({intf_req_o, cmd_resp_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: got %h want 0", {intf_req_o, cmd_resp_o});
        end
        rst_i = 1'b0;
        mdl_clear();
        tick();
    endtask

    task automatic test_basic();
        pspin_cmd_req_t  r;
        pspin_cmd_resp_t p;
        int fid;
        fid = 1*32 + 2*4 + 3;
        r.cmd_id = '{cluster_id: 2'd1, core_id: 3'd2, local_cmd_id: 2'd3};
        r.generate_event = 1'b1;
        r.intf_id = 2'd1;
        r.descr = $urandom;
        cmd_req_i = r;
        cmd_req_valid_i = 1'b1;
        tick();
        cmd_req_valid_i = 1'b0;
        mdl_sb[fid] = 1'b1;
        mdl_ev[fid] = 1'b1;
        n_chk++;
        if (intf_req_valid_o !== 3'b010) begin n_fail++; $display("FAIL basic_valid: got %b want 010", intf_req_valid_o); end
        n_chk++;
        if (intf_req_o !== r) begin n_fail++; $display("FAIL basic_payload: got %h want %h", intf_req_o, r); end
        n_chk++;
        if (inflight_cnt_o !== 8'(mdl_cnt())) begin n_fail++; $display("FAIL basic_cnt_issue: got %0d want %0d", inflight_cnt_o, mdl_cnt()); end
        n_chk++;
        if (cmd_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL basic_ready_blocked: got %b want 0", cmd_req_ready_o); end
        intf_req_ready_i = 3'b010;
        #1;
        n_chk++;
        if (cmd_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL basic_ready_hs: got %b want 1", cmd_req_ready_o); end
        tick();
        intf_req_ready_i = '0;
        p = mk_resp(fid);
        intf_resp_i[1] = p;
        intf_resp_valid_i = 3'b010;
        #1;
        n_chk++;
        if (intf_resp_ready_o !== 3'b010) begin n_fail++; $display("FAIL basic_resp_ready: got %b want 010", intf_resp_ready_o); end
        tick();
        intf_resp_valid_i = '0;
        mdl_sb[fid] = 1'b0;
        n_chk++;
        if (cmd_resp_valid_o !== 1'b1 || cmd_resp_o !== p) begin n_fail++; $display("FAIL basic_resp: got %b/%h want 1/%h", cmd_resp_valid_o, cmd_resp_o, p); end
        n_chk++;
        if (inflight_cnt_o !== 8'(mdl_cnt())) begin n_fail++; $display("FAIL basic_cnt_retire: got %0d want %0d", inflight_cnt_o, mdl_cnt()); end
        cmd_resp_ready_i = 1'b1;
        tick();
        cmd_resp_ready_i = 1'b0;
        n_chk++;
        if (cmd_resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_resp_drain: got %b want 0", cmd_resp_valid_o); end
    endtask

    task automatic test_back_to_back();
        pspin_cmd_req_t r[4];
        int ifs[4];
        ifs = '{0, 1, 2, 0};
        intf_req_ready_i = '1;
        for (int k = 0; k < 4; k++) begin
            r[k] = mk_req(100 + k, ifs[k], 1'b1);
            cmd_req_i = r[k];
            cmd_req_valid_i = 1'b1;
            #1;
            n_chk++;
            if (cmd_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, cmd_req_ready_o); end
            tick();
            mdl_sb[100 + k] = 1'b1;
            mdl_ev[100 + k] = 1'b1;
            n_chk++;
            if (intf_req_valid_o !== 3'(1 << ifs[k]) || intf_req_o !== r[k]) begin
                n_fail++;
                $display("FAIL b2b_out[%0d]: got %b/%h want %b/%h", k, intf_req_valid_o, intf_req_o, 3'(1 << ifs[k]), r[k]);
            end
            n_chk++;
            if (inflight_cnt_o !== 8'(mdl_cnt())) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", k, inflight_cnt_o, mdl_cnt()); end
        end
        cmd_req_valid_i = 1'b0;
        tick();
        intf_req_ready_i = '0;
        n_chk++;
        if (intf_req_valid_o !== 3'b000) begin n_fail++; $display("FAIL b2b_empty: got %b want 000", intf_req_valid_o); end
    endtask

    task automatic test_dup_oob();
        int base;
        base = mdl_cnt();
        cmd_req_i = mk_req(100, 1, 1'b1);
        cmd_req_valid_i = 1'b1;
        tick();
        cmd_req_valid_i = 1'b0;
        n_chk++;
        if (err_o !== 1'b1 || intf_req_valid_o !== 3'b000) begin n_fail++; $display("FAIL dup_drop: got err=%b valid=%b want 1/000", err_o, intf_req_valid_o); end
        n_chk++;
        if (inflight_cnt_o !== 8'(base)) begin n_fail++; $display("FAIL dup_cnt: got %0d want %0d", inflight_cnt_o, base); end
        tick();
        n_chk++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL dup_pulse: got %b want 0", err_o); end
        cmd_req_i = mk_req(90, 3, 1'b1);
        cmd_req_valid_i = 1'b1;
        tick();
        cmd_req_valid_i = 1'b0;
        n_chk++;
        if (err_o !== 1'b1 || intf_req_valid_o !== 3'b000 || inflight_cnt_o !== 8'(base)) begin
            n_fail++;
            $display("FAIL oob_drop: got err=%b valid=%b cnt=%0d want 1/000/%0d", err_o, intf_req_valid_o, inflight_cnt_o, base);
        end
        tick();
    endtask

    task automatic test_no_event();
        cmd_req_i = mk_req(60, 2, 1'b0);
        cmd_req_valid_i = 1'b1;
        intf_req_ready_i = '1;
        tick();
        cmd_req_valid_i = 1'b0;
        tick();
        intf_req_ready_i = '0;
        mdl_sb[60] = 1'b1;
        mdl_ev[60] = 1'b0;
        intf_resp_i[2] = mk_resp(60);
        intf_resp_valid_i = 3'b100;
        tick();
        intf_resp_valid_i = '0;
        mdl_sb[60] = 1'b0;
        n_chk++;
        if (cmd_resp_valid_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL noev_silent: got valid=%b err=%b want 0/0", cmd_resp_valid_o, err_o); end
        n_chk++;
        if (inflight_cnt_o !== 8'(mdl_cnt())) begin n_fail++; $display("FAIL noev_cnt: got %0d want %0d", inflight_cnt_o, mdl_cnt()); end
        intf_resp_i[0] = mk_resp(70);
        intf_resp_valid_i = 3'b001;
        tick();
        intf_resp_valid_i = '0;
        n_chk++;
        if (err_o !== 1'b1 || cmd_resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL unknown_id: got err=%b valid=%b want 1/0", err_o, cmd_resp_valid_o); end
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int fid, intf;
            bit ev, exp_err, exp_rv;
            pspin_cmd_req_t  r;
            pspin_cmd_resp_t p;
            fid = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0) begin
                intf = $urandom_range(0, 3);
                ev = 1'($urandom_range(0, 1));
                r = mk_req(fid, intf, ev);
                exp_err = (intf >= NI) || mdl_sb[fid];
                cmd_req_i = r;
                cmd_req_valid_i = 1'b1;
                intf_req_ready_i = '1;
                tick();
                cmd_req_valid_i = 1'b0;
                if (!exp_err) begin
                    mdl_sb[fid] = 1'b1;
                    mdl_ev[fid] = ev;
                end
                n_chk++;
                if (err_o !== exp_err || intf_req_valid_o !== (exp_err ? 3'b000 : 3'(1 << intf))) begin
                    n_fail++;
                    $display("FAIL rnd_issue[%0d]: got err=%b valid=%b want %b/%b", it, err_o, intf_req_valid_o, exp_err, exp_err ? 3'b000 : 3'(1 << intf));
                end
                n_chk++;
                if (inflight_cnt_o !== 8'(mdl_cnt())) begin n_fail++; $display("FAIL rnd_issue_cnt[%0d]: got %0d want %0d", it, inflight_cnt_o, mdl_cnt()); end
                tick();
                intf_req_ready_i = '0;
            end else begin
                intf = $urandom_range(0, NI - 1);
                p = mk_resp(fid);
                intf_resp_i[intf] = p;
                intf_resp_valid_i = 3'(1 << intf);
                cmd_resp_ready_i = 1'b1;
                #1;
                n_chk++;
                if (intf_resp_ready_o !== 3'(1 << intf)) begin n_fail++; $display("FAIL rnd_grant[%0d]: got %b want %b", it, intf_resp_ready_o, 3'(1 << intf)); end
                tick();
                intf_resp_valid_i = '0;
                exp_err = !mdl_sb[fid];
                exp_rv = mdl_sb[fid] && mdl_ev[fid];
                mdl_sb[fid] = 1'b0;
                n_chk++;
                if (err_o !== exp_err || cmd_resp_valid_o !== exp_rv || (exp_rv && cmd_resp_o !== p)) begin
                    n_fail++;
                    $display("FAIL rnd_retire[%0d]: got err=%b valid=%b resp=%h want %b/%b/%h", it, err_o, cmd_resp_valid_o, cmd_resp_o, exp_err, exp_rv, p);
                end
                n_chk++;
                if (inflight_cnt_o !== 8'(mdl_cnt())) begin n_fail++; $display("FAIL rnd_retire_cnt[%0d]: got %0d want %0d", it, inflight_cnt_o, mdl_cnt()); end
                tick();
                cmd_resp_ready_i = 1'b0;
            end
        end
    endtask

    task automatic test_simultaneous();
        int base;
        cmd_req_i = mk_req(81, 1, 1'b0);
        cmd_req_valid_i = 1'b1;
        intf_req_ready_i = '1;
        tick();
        cmd_req_valid_i = 1'b0;
        tick();
        mdl_sb[81] = 1'b1;
        mdl_ev[81] = 1'b0;
        base = mdl_cnt();
        cmd_req_i = mk_req(80, 0, 1'b0);
        cmd_req_valid_i = 1'b1;
        intf_resp_i[0] = mk_resp(81);
        intf_resp_valid_i = 3'b001;
        cmd_resp_ready_i = 1'b1;
        tick();
        cmd_req_valid_i = 1'b0;
        intf_resp_valid_i = '0;
        mdl_sb[80] = 1'b1;
        mdl_ev[80] = 1'b0;
        mdl_sb[81] = 1'b0;
        n_chk++;
        if (inflight_cnt_o !== 8'(base) || err_o !== 1'b0 || intf_req_valid_o !== 3'b001) begin
            n_fail++;
            $display("FAIL simul_issue_retire: got cnt=%0d err=%b valid=%b want %0d/0/001", inflight_cnt_o, err_o, intf_req_valid_o, base);
        end
        tick();
        cmd_req_i = mk_req(80, 0, 1'b0);
        cmd_req_valid_i = 1'b1;
        tick();
        cmd_req_valid_i = 1'b0;
        n_chk++;
        if (err_o !== 1'b1) begin n_fail++; $display("FAIL simul_a_set: got err=%b want 1", err_o); end
        intf_resp_i[2] = mk_resp(81);
        intf_resp_valid_i = 3'b100;
        tick();
        intf_resp_valid_i = '0;
        n_chk++;
        if (err_o !== 1'b1) begin n_fail++; $display("FAIL simul_b_clear: got err=%b want 1", err_o); end
        cmd_req_i = mk_req(80, 2, 1'b0);
        cmd_req_valid_i = 1'b1;
        intf_resp_i[1] = mk_resp(80);
        intf_resp_valid_i = 3'b010;
        tick();
        cmd_req_valid_i = 1'b0;
        intf_resp_valid_i = '0;
        mdl_sb[80] = 1'b0;
        n_chk++;
        if (err_o !== 1'b1 || inflight_cnt_o !== 8'(mdl_cnt()) || intf_req_valid_o !== 3'b000) begin
            n_fail++;
            $display("FAIL simul_same_id: got err=%b cnt=%0d valid=%b want 1/%0d/000", err_o, inflight_cnt_o, intf_req_valid_o, mdl_cnt());
        end
        tick();
        idle();
    endtask

    task automatic test_arb_backpressure();
        pspin_cmd_resp_t rs[3];
        idle();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        mdl_clear();
        intf_req_ready_i = '1;
        for (int k = 0; k < 3; k++) begin
            cmd_req_i = mk_req(10 + k, k, 1'b1);
            cmd_req_valid_i = 1'b1;
            tick();
            mdl_sb[10 + k] = 1'b1;
            mdl_ev[10 + k] = 1'b1;
        end
        cmd_req_valid_i = 1'b0;
        tick();
        intf_req_ready_i = '0;
        for (int k = 0; k < 3; k++) begin
            rs[k] = mk_resp(10 + k);
            intf_resp_i[k] = rs[k];
        end
        intf_resp_valid_i = 3'b111;
        #1;
        n_chk++;
        if (intf_resp_ready_o !== 3'b001) begin n_fail++; $display("FAIL arb_first: got %b want 001", intf_resp_ready_o); end
        tick();
        intf_resp_valid_i[0] = 1'b0;
        mdl_sb[10] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_chk++;
            if (cmd_resp_valid_o !== 1'b1 || cmd_resp_o !== rs[0] || intf_resp_ready_o !== 3'b000) begin
                n_fail++;
                $display("FAIL arb_hold[%0d]: got %b/%h/%b want 1/%h/000", c, cmd_resp_valid_o, cmd_resp_o, intf_resp_ready_o, rs[0]);
            end
            tick();
        end
        cmd_resp_ready_i = 1'b1;
        for (int k = 1; k < 3; k++) begin
            #1;
            n_chk++;
            if (intf_resp_ready_o !== 3'(1 << k)) begin n_fail++; $display("FAIL arb_order_grant[%0d]: got %b want %b", k, intf_resp_ready_o, 3'(1 << k)); end
            tick();
            intf_resp_valid_i[k] = 1'b0;
            mdl_sb[10 + k] = 1'b0;
            n_chk++;
            if (cmd_resp_valid_o !== 1'b1 || cmd_resp_o !== rs[k]) begin
                n_fail++;
                $display("FAIL arb_order_resp[%0d]: got %b/%h want 1/%h", k, cmd_resp_valid_o, cmd_resp_o, rs[k]);
            end
        end
        tick();
        n_chk++;
        if (cmd_resp_valid_o !== 1'b0 || inflight_cnt_o !== 8'(mdl_cnt())) begin
            n_fail++;
            $display("FAIL arb_done: got valid=%b cnt=%0d want 0/%0d", cmd_resp_valid_o, inflight_cnt_o, mdl_cnt());
        end
        idle();
    endtask

    task automatic test_reset_midop();
        cmd_req_i = mk_req(20, 1, 1'b1);
        cmd_req_valid_i = 1'b1;
        tick();
        cmd_req_valid_i = 1'b0;
        n_chk++;
        if (intf_req_valid_o !== 3'b010 || inflight_cnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL midrst_full: got valid=%b cnt=%0d want 010/1", intf_req_valid_o, inflight_cnt_o);
        end
        rst_i = 1'b1;
        tick();
        n_chk++;
        if ({cmd_req_ready_o, intf_req_valid_o, intf_resp_ready_o, cmd_resp_valid_o, inflight_cnt_o, err_o} !== 17'h10000) begin
            n_fail++;
            $display("FAIL midrst_ctrl: got %h want 10000", {cmd_req_ready_o, intf_req_valid_o, intf_resp_ready_o, cmd_resp_valid_o, inflight_cnt_o, err_o});
        end
        n_chk++;
        if ({intf_req_o, cmd_resp_o} !== '0) begin n_fail++; $display("FAIL midrst_payload: got %h want 0", {intf_req_o, cmd_resp_o}); end
        rst_i = 1'b0;
        mdl_clear();
        cmd_req_valid_i = 1'b1;
        tick();
        cmd_req_valid_i = 1'b0;
        mdl_sb[20] = 1'b1;
        n_chk++;
        if (err_o !== 1'b0 || inflight_cnt_o !== 8'(mdl_cnt())) begin
            n_fail++;
            $display("FAIL midrst_sb_cleared: got err=%b cnt=%0d want 0/%0d", err_o, inflight_cnt_o, mdl_cnt());
        end
        intf_req_ready_i = '1;
        tick();
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_dup_oob();
        test_no_event();
        test_random();
        test_simultaneous();
        test_arb_backpressure();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
